// File: rtl/output_packer_pkg.sv
// Shared configuration and entry types for the output scaler / packer slice.
package output_packer_pkg;

  typedef struct packed {
    int unsigned numElements;
    int unsigned outputWidth;
  } cfg_oscaler_t;

  typedef struct packed {
    int unsigned busWidth;
    int unsigned fifoDepth;
  } cfg_opacker_t;

  localparam int DEF_BUS_W      = 128;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_STRB_W     = DEF_BUS_W / 8;

  localparam cfg_opacker_t OPACKER_DEFAULT_CFG = '{busWidth: 32'd128, fifoDepth: 32'd4};

  // Layout of one buffered writeback word; the FIFO stores it flattened in this order.
  typedef struct packed {
    logic [DEF_BUS_W-1:0]  data;
    logic [DEF_STRB_W-1:0] strb;
    logic                  last;
  } opack_entry_t;

  function automatic int strb_bits(input int data_bits);
    return data_bits / 8;
  endfunction

endpackage

// File: rtl/output_packer_fifo.sv
// Synchronous FIFO of packed writeback words; head reads zero when empty.
module sync_fifo #(
  parameter int WIDTH = 145,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push_s;
  logic             do_pop_s;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == {CNT_W{1'b0}});
  assign do_push_s = push_i & ~full_o;
  // A push into an empty FIFO is never popped in the same cycle.
  assign do_pop_s  = pop_i & ~empty_o;

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop_s)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Head presentation.
  always_comb begin
    head_o = {WIDTH{1'b0}};
    if (empty_o) begin
      head_o = {WIDTH{1'b0}};
    end else begin
      head_o = mem_q[rd_ptr_q];
    end
  end

endmodule

// File: rtl/output_packer.sv
// Packs scaler activation beats into bus-wide writeback words with byte strobes.
module output_packer
  import output_packer_pkg::*;
#(
  parameter int numElements = 4,
  parameter int outputWidth = 8,
  parameter int busWidth    = DEF_BUS_W,
  parameter int fifoDepth   = DEF_FIFO_DEPTH
) (
  input  logic                                       clk,
  input  logic                                       nrst,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic signed [numElements-1:0][outputWidth-1:0] y_i,
  input  logic                                       in_last,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [busWidth-1:0]                        out_data,
  output logic [strb_bits(busWidth)-1:0]             out_strb,
  output logic                                       out_last
);
  localparam int BEAT_W    = numElements * outputWidth;
  localparam int BPW       = busWidth / BEAT_W;
  localparam int STRB_W    = strb_bits(busWidth);
  localparam int BEAT_STRB = strb_bits(BEAT_W);
  localparam int CNT_W     = $clog2(BPW);
  localparam int ENTRY_W   = busWidth + STRB_W + 1;

  logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [busWidth-1:0] pack_data_q, pack_data_d;
  logic [STRB_W-1:0]   pack_strb_q, pack_strb_d;
  logic [BEAT_W-1:0]   y_flat_s;
  logic [busWidth-1:0] merged_data_s;
  logic [STRB_W-1:0]   merged_strb_s;
  logic                accept_s;
  logic                close_s;
  logic                fifo_full_s;
  logic                fifo_empty_s;
  logic [ENTRY_W-1:0]  head_s;

  // Unsigned view so widening below zero-extends instead of sign-extending.
  assign y_flat_s      = y_i;
  assign in_ready      = ~fifo_full_s;
  assign out_valid     = ~fifo_empty_s;
  assign accept_s      = in_valid & in_ready;
  assign close_s       = accept_s & ((beat_cnt_q == CNT_W'(BPW - 1)) | in_last);
  assign merged_data_s = pack_data_q | (busWidth'(y_flat_s) << (int'(beat_cnt_q) * BEAT_W));
  assign merged_strb_s = pack_strb_q |
                         (STRB_W'({BEAT_STRB{1'b1}}) << (int'(beat_cnt_q) * BEAT_STRB));
  assign {out_data, out_strb, out_last} = head_s;

  // Pack-path next state: clear on close, merge on a plain accept, else hold.
  always_comb begin
    beat_cnt_d  = beat_cnt_q;
    pack_data_d = pack_data_q;
    pack_strb_d = pack_strb_q;
    if (close_s) begin
      beat_cnt_d  = {CNT_W{1'b0}};
      pack_data_d = {busWidth{1'b0}};
      pack_strb_d = {STRB_W{1'b0}};
    end else if (accept_s) begin
      beat_cnt_d  = beat_cnt_q + CNT_W'(1);
      pack_data_d = merged_data_s;
      pack_strb_d = merged_strb_s;
    end else begin
      beat_cnt_d  = beat_cnt_q;
    end
  end

  // Pack-path state registers.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      beat_cnt_q  <= {CNT_W{1'b0}};
      pack_data_q <= {busWidth{1'b0}};
      pack_strb_q <= {STRB_W{1'b0}};
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      pack_data_q <= pack_data_d;
      pack_strb_q <= pack_strb_d;
    end
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (fifoDepth)
  ) u_fifo (
    .clk         (clk),
    .nrst        (nrst),
    .push_i      (close_s),
    .push_data_i ({merged_data_s, merged_strb_s, in_last}),
    .pop_i       (out_ready),
    .head_o      (head_s),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s)
  );

endmodule

// File: tb/tb_output_packer.sv
// Randomized bench for output_packer against a word-list reference model.
module tb_output_packer;
  localparam int DEPTH = 4;
  localparam int BPW   = 4;

  logic                   clk = 1'b0;
  logic                   nrst = 1'b0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic signed [3:0][7:0] y = '0;
  logic                   in_last = 1'b0;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [127:0]           out_data;
  logic [15:0]            out_strb;
  logic                   out_last;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [127:0] d;
    logic [15:0]  s;
    logic         l;
  } word_t;

  word_t       mq[$];
  logic [31:0] cur[BPW];
  int          cur_n = 0;
  bit          started = 1'b0;

  output_packer dut (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready), .y_i(y),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_strb(out_strb), .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: word list built from collected beats, FIFO as a queue.
  always @(posedge clk) begin
    word_t w;
    bit    acc;
    bit    pop;
    started = 1'b1;
    if (!nrst) begin
      mq.delete();
      cur_n = 0;
    end else begin
      acc = in_valid && (mq.size() < DEPTH);
      pop = (mq.size() > 0) && out_ready;
      if (pop) void'(mq.pop_front());
      if (acc) begin
        cur[cur_n] = y;
        cur_n++;
        if (cur_n == BPW || in_last) begin
          w.d = '0;
          w.s = '0;
          for (int k = 0; k < cur_n; k++) begin
            w.d = w.d | (128'(cur[k]) << (32 * k));
            w.s = w.s | (16'hF << (4 * k));
          end
          w.l = in_last;
          mq.push_back(w);
          cur_n = 0;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", 128'(in_ready), 128'(mq.size() < DEPTH));
      chk("out_valid", 128'(out_valid), 128'(mq.size() > 0));
      if (mq.size() > 0) begin
        chk("out_data", out_data, mq[0].d);
        chk("out_strb", 128'(out_strb), 128'(mq[0].s));
        chk("out_last", 128'(out_last), 128'(mq[0].l));
      end else begin
        chk("idle_data", out_data, 128'd0);
        chk("idle_strb", 128'(out_strb), 128'd0);
        chk("idle_last", 128'(out_last), 128'd0);
      end
    end
  end

  task automatic beat(input logic [31:0] v, input logic last);
    @(negedge clk);
    in_valid = 1'b1;
    y        = v;
    in_last  = last;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    chk("rst_valid", 128'(out_valid), 128'd0);
    chk("rst_ready", 128'(in_ready), 128'd1);
    chk("rst_data", out_data, 128'd0);

    // Full word of four beats.
    out_ready = 1'b1;
    beat(32'h04030201, 1'b0);
    beat(32'h08070605, 1'b0);
    beat(32'h0C0B0A09, 1'b0);
    beat(32'h100F0E0D, 1'b0);
    idle();
    chk("t1_valid", 128'(out_valid), 128'd1);
    chk("t1_data", out_data, 128'h100F0E0D_0C0B0A09_08070605_04030201);
    chk("t1_strb", 128'(out_strb), 128'hFFFF);
    chk("t1_last", 128'(out_last), 128'd0);

    // Partial word closed by in_last, negatives bit-exact, then restart at lane 0.
    idle();
    beat(32'h817FFF00, 1'b0);
    beat(32'h8001FE7F, 1'b1);
    beat(32'hAABBCCDD, 1'b1);
    chk("t2_data", out_data, 128'h8001FE7F_817FFF00);
    chk("t2_strb", 128'(out_strb), 128'h00FF);
    chk("t2_last", 128'(out_last), 128'd1);
    idle();
    chk("t2_next_data", out_data, 128'hAABBCCDD);
    chk("t2_next_strb", 128'(out_strb), 128'h000F);

    // Fill the FIFO with out_ready low, then release.
    idle();
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) beat({4{8'(i + 1)}}, 1'b0);
    @(negedge clk);
    chk("t3_full_ready", 128'(in_ready), 128'd0);
    chk("t3_head", out_data, 128'h04040404_03030303_02020202_01010101);
    out_ready = 1'b1;
    #1;
    chk("t3_no_fallthru", 128'(in_ready), 128'd0);
    repeat (6) idle();

    // Continuous input with out_ready alternating.
    for (int c = 0; c < 300; c++) begin
      beat($urandom, ($urandom_range(0, 7) == 0));
      out_ready = ((c % 2) == 0);
    end
    // Fully random traffic.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      y         = $urandom;
      in_last   = ($urandom_range(0, 5) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
    end

    // Reset with one queued word and a half-built word pending.
    idle();
    out_ready = 1'b1;
    repeat (6) idle();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) beat(32'hDEADBEEF, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    nrst     = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    chk("t5_valid", 128'(out_valid), 128'd0);
    chk("t5_ready", 128'(in_ready), 128'd1);
    out_ready = 1'b1;
    beat(32'h11111111, 1'b0);
    beat(32'h22222222, 1'b0);
    beat(32'h33333333, 1'b0);
    beat(32'h44444444, 1'b0);
    idle();
    chk("t5_data", out_data, 128'h44444444_33333333_22222222_11111111);
    chk("t5_strb", 128'(out_strb), 128'hFFFF);
    repeat (3) idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/output_packer.md
Name: output_packer

Overview:
- Sits directly downstream of the output scaler.
- Collects the saturated signed activation vectors the scaler produces (numElements x outputWidth per beat) and packs several beats into one busWidth-wide writeback word with byte strobes.
- Buffers packed words in a small FIFO and presents them to the activation-memory write port over a valid/ready handshake.
- in_last closes a partial word at the end of a row or tile.

Parameters:
- numElements, 4, activation lanes per input beat (matches the scaler's numElements).
- outputWidth, 8, bits per activation lane (matches the scaler's outputWidth).
- busWidth, 128, output word width. Must be an integer multiple of numElements*outputWidth.
- fifoDepth, 4, packed words buffered. Power of two, at least 2.
- Derived beatsPerWord = busWidth/(numElements*outputWidth), default 4. Must be at least 2.
- Derived strbWidth = busWidth/8. numElements*outputWidth must be a multiple of 8.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- nrst  in  1  synchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- y_i  in  [numElements-1:0][outputWidth-1:0] signed  activation vector from the scaler.
- in_last  in  1  this beat closes the current word (end of row or tile).
- out_valid  out  1  FIFO head word valid.
- out_ready  in  1  memory accepts the head word.
- out_data  out  busWidth  packed word.
- out_strb  out  strbWidth  byte write-enables for out_data.
- out_last  out  1  word was closed by in_last.

Behaviour:
- Reset (nrst low at a clk edge):
  - beat_cnt=0, pack_data=0, pack_strb=0; FIFO emptied.
  - Outputs after reset: out_valid=0, out_data=0, out_strb=0, out_last=0, in_ready=1.
  - Reset mid-word or with a non-empty FIFO discards all pending data; nothing partial is emitted afterwards.
- Input accept: a beat is accepted when in_valid & in_ready.
- in_ready is !fifo_full and is registered-state-derived only, with no combinational path from out_ready.
  - When the FIFO is full, input stalls even if out_ready=1 that cycle (no fall-through).
- Lane placement: for an accepted beat b = beat_cnt, element i goes to pack_data[(b*numElements+i)*outputWidth +: outputWidth].
  - The bytes covered by those lanes get their pack_strb bits set.
  - Bits are copied verbatim; no sign handling or arithmetic.
- Word close: a word closes on an accepted beat when beat_cnt==beatsPerWord-1 or in_last==1.
  - On close, {pack_data merged with this beat, pack_strb merged, in_last} is pushed into the FIFO in the same cycle.
  - Then beat_cnt=0 and pack_data, pack_strb are cleared to 0.
  - Otherwise beat_cnt increments.
  - Unwritten lanes of a partial word carry data 0 and strobe 0.
  - A full word that also has in_last set gives out_last=1 with all strobes set.
- Latency: a word closed at edge N is visible on out_valid/out_data at cycle N+1 when the FIFO was empty (one register stage).
- Output:
  - out_valid = !fifo_empty; out_data, out_strb, out_last show the FIFO head.
  - Pop on out_valid & out_ready.
  - While out_valid=1 and out_ready=0, the head stays stable.
  - When the FIFO is empty, out_data, out_strb and out_last read 0.
- Simultaneous push and pop: when the FIFO is neither full nor empty, count is unchanged and ordering is preserved.
  - Push into an empty FIFO with out_ready=1 in the same cycle is not popped that cycle.
- FIFO pointers wrap modulo fifoDepth; full and empty come from a count of width $clog2(fifoDepth)+1.
- in_valid=0: no state change in the pack path. y_i and in_last are ignored.

Decomposition:
- Shared package:
  - packer config typedef cfg_opacker_t with fields busWidth and fifoDepth, next to the existing oscaler config typedef.
  - Typedef for a FIFO entry struct {data, strb, last}.
- Sub-module sync_fifo (parameterised width/depth, synchronous active-low reset), holding the {data, strb, last} entries.
- output_packer holds the beat counter, pack register and close logic only.

Test Plan:
- Four beats with y_i = {8'h04,8'h03,8'h02,8'h01}, {8'h08,..,8'h05}, {8'h0C..8'h09}, {8'h10..8'h0D}, out_ready=1 -> one word, out_data = 128'h100F0E0D_0C0B0A09_08070605_04030201, out_strb = 16'hFFFF, out_last = 0, out_valid high one cycle after the 4th beat.
- Two beats {8'h81,8'h7F,8'hFF,8'h00} then {8'h80,...} with in_last on the second -> out_strb = 16'h00FF, upper 64 bits = 0, out_last = 1, negatives passed bit-exact; the next beat lands at lane 0 of a new word.
- out_ready=0 with 16 beats streamed -> 4 words queued, in_ready drops to 0 the cycle after the 4th push; in_ready stays 0 in the cycle out_ready rises; words drain in order with unchanged data.
- Continuous input with out_ready toggling 1010... -> no beat lost or duplicated; a scoreboard matches every word.
- nrst low for one edge after 2 beats with 1 word queued -> out_valid = 0, in_ready = 1; the next 4 beats form a clean word with no residue from before reset.
